keypad_scanner: RTL and testbench

Matrix-keypad front end for the digital alarm clock: drives the 4x3 keypad rows, samples the columns, debounces, and presents one stable BCD key code to the alarm controller's `key` input. The code is held while the key is down and reads `4'd10` (no key) when released. The controller relies on that release value to leave KEY_WAIT, so it is a hard requirement. A one-cycle `key_valid` strobe marks each newly accepted digit.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_col_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, key map lookup and debounce state type for
// the keypad scanner.
package keypad_pkg;

    localparam int          ROWS   = 4;
    localparam int          COLS   = 3;
    localparam logic [3:0]  NO_KEY = 4'd10;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } deb_state_t;

    // Map a (row, col) switch position to its BCD code; '*' and '#' read as NO_KEY.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = NO_KEY;
        if (col < 2'd3) begin
            if (row < 2'd3) begin
                code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
            end else if (col == 2'd1) begin
                code = 4'd0;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchronizer for the asynchronous, active-low
// keypad columns. Resets to all-ones (no switch closed).
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] col_n,
    output logic [COLS-1:0] col_n_sync
);

    logic [COLS-1:0] meta;

    // Two-stage synchronizer chain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, regardless of statement order.
        if (reset) begin
            meta       <= '1;
            col_n_sync <= '1;
        end else begin
            meta       <= col_n;
            col_n_sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives 4x3 keypad rows, samples synchronized columns once
// per row period, picks one candidate key per frame and debounces it into a
// stable BCD key code with a one-cycle key_valid strobe.
// Optional build macro: KEYPAD_SCANNER_GHOST_REJECT_EN -- when defined, a frame
// with more than one closed switch yields no candidate (ghost suppression).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_CNT  = 4'(DEBOUNCE);
    localparam int          NSW      = ROWS * COLS;

    logic [COLS-1:0] col_n_sync;
    logic [15:0]     div_cnt;
    logic [1:0]      row_idx;
    logic            sample_now;
    logic            frame_end;
    logic [NSW-1:0]  closed_q;
    logic [NSW-1:0]  closed_now;
    logic [3:0]      first_code;
    logic [3:0]      candidate;

    deb_state_t      state, state_d;
    logic [3:0]      cnt, cnt_d;
    logic [3:0]      pend, pend_d;
    logic [3:0]      key_q, key_d;
    logic            valid_q, valid_d;

    keypad_col_sync u_col_sync (
        .clk        (clk),
        .reset      (reset),
        .col_n      (col_n),
        .col_n_sync (col_n_sync)
    );

    assign sample_now = (div_cnt == DIV_LAST);
    assign frame_end  = sample_now && (row_idx == 2'(ROWS - 1));
    assign row_n      = ~(4'b0001 << row_idx);

    // Row period divider and row counter; the row advances after its sample cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            row_idx <= '0;
        end else if (sample_now) begin
            div_cnt <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Merge the live column sample into the frame's switch map for the current row.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        closed_now = closed_q;
        closed_now[row_idx * COLS +: COLS] = ~col_n_sync;
    end

    // Keep each row's sample until the frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            closed_q <= '0;
        end else if (sample_now) begin
            closed_q <= closed_now;
        end
    end

    // Lowest-index closed switch wins; scanning downward leaves the lowest last.
    always_comb begin
        first_code = NO_KEY;
        for (int i = NSW - 1; i >= 0; i--) begin
            if (closed_now[i]) begin
                first_code = key_code(2'(i / COLS), 2'(i % COLS));
            end
        end
    end

`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
    logic [3:0] n_closed;

    // Count closed switches so multi-key frames can be discarded.
    always_comb begin
        n_closed = '0;
        for (int i = 0; i < NSW; i++) begin
            if (closed_now[i]) begin
                n_closed = n_closed + 4'd1;
            end
        end
    end

    assign candidate = (n_closed > 4'd1) ? NO_KEY : first_code;
`else
    assign candidate = first_code;
`endif

    // Debounce state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            pend    <= '0;
            key_q   <= NO_KEY;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            pend    <= pend_d;
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end

    // Debounce next-state logic, evaluated only on the frame-end cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pend_d  = pend;
        key_d   = key_q;
        valid_d = 1'b0;
        if (frame_end) begin
            case (state)
                RELEASED: begin
                    if (candidate != NO_KEY) begin
                        state_d = PRESS_PEND;
                        pend_d  = candidate;
                        cnt_d   = 4'd1;
                    end
                end
                PRESS_PEND: begin
                    if (candidate == pend) begin
                        cnt_d = cnt + 4'd1;
                        if (cnt_d == DEB_CNT) begin
                            state_d = PRESSED;
                            key_d   = pend;
                            valid_d = 1'b1;
                        end
                    end else if (candidate != NO_KEY) begin
                        pend_d = candidate;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = RELEASED;
                    end
                end
                PRESSED: begin
                    if (candidate != key_q) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASE_PEND: begin
                    if (candidate == key_q) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt + 4'd1;
                        if (cnt_d == DEB_CNT) begin
                            state_d = RELEASED;
                            key_d   = NO_KEY;
                        end
                    end
                end
                default: begin
                    state_d = RELEASED;
                end
            endcase
        end
    end

    assign key       = key_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed plus randomized keypad stimulus checked against a
// frame-level streak model of the debounce rules.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       key_valid;

    // Switch matrix, bit index = row*3 + col.
    logic [11:0] keys = '0;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_key      = 10;
    int m_run_code = 10;
    int m_run      = 0;
    int m_off      = 0;
    bit m_pulse    = 1'b0;
    int code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 10};

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .key       (key),
        .key_valid (key_valid)
    );

    // Passive keypad: a closed switch pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[r * 3 + c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame of the model: pick the frame's key, then apply streak rules.
    task automatic model_frame();
        int cand;
        int n;
        cand = 10;
        n = 0;
        for (int i = 11; i >= 0; i--) begin
            if (keys[i]) begin
                cand = code_tab[i];
                n++;
            end
        end
`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
        if (n > 1) cand = 10;
`endif
        m_pulse = 1'b0;
        if (m_key == 10) begin
            if (cand == 10) m_run = 0;
            else if (cand == m_run_code) m_run++;
            else begin
                m_run_code = cand;
                m_run = 1;
            end
            if (m_run == DEBOUNCE) begin
                m_key = cand;
                m_pulse = 1'b1;
                m_run = 0;
            end
        end else begin
            if (cand != m_key) m_off++;
            else m_off = 0;
            if (m_off == DEBOUNCE) begin
                m_key = 10;
                m_off = 0;
                m_run = 0;
            end
        end
    endtask

    // Hold a switch pattern for ncyc cycles starting at a frame boundary.
    task automatic run_frame(input logic [11:0] k, input int ncyc = FRAME);
        logic [3:0] exp_row;
        keys = k;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            if (c == FRAME - 1) model_frame();
            @(negedge clk);
            exp_row = ~(4'b0001 << (((c + 1) / SCAN_DIV) % 4));
            check("row_n", {28'd0, row_n}, {28'd0, exp_row});
            check("key", {28'd0, key}, m_key);
            check("key_valid", {31'd0, key_valid}, (c == FRAME - 1) ? {31'd0, m_pulse} : 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row_n", {28'd0, row_n}, 32'b1110);
        check("rst_key", {28'd0, key}, 32'd10);
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        reset = 1'b0;
        m_key = 10;
        m_run_code = 10;
        m_run = 0;
        m_off = 0;
    endtask

    initial begin
        logic [11:0] k;
        int sel;
        int hold;

        do_reset();

        // Idle scan.
        repeat (10) run_frame(12'd0);

        // Digit 6 (r1c2): accept at end of frame 4, release after 4 clean frames.
        repeat (4) run_frame(12'b1 << 5);
        check("key6_accept", {28'd0, key}, 32'd6);
        repeat (4) run_frame(12'b1 << 5);
        repeat (3) run_frame(12'd0);
        check("key6_still_held", {28'd0, key}, 32'd6);
        run_frame(12'd0);
        check("key6_release", {28'd0, key}, 32'd10);
        repeat (2) run_frame(12'd0);

        // Digit 8 (r2c1) bouncing, then steady.
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? (12'b1 << 7) : 12'd0);
        repeat (3) run_frame(12'b1 << 7);
        check("key8_not_yet", {28'd0, key}, 32'd10);
        run_frame(12'b1 << 7);
        check("key8_accept", {28'd0, key}, 32'd8);
        repeat (2) run_frame(12'b1 << 7);
        repeat (5) run_frame(12'd0);

        // '*' and '#' alone are ignored.
        repeat (6) run_frame(12'b1 << 9);
        check("star_ignored", {28'd0, key}, 32'd10);
        repeat (6) run_frame(12'b1 << 11);
        check("hash_ignored", {28'd0, key}, 32'd10);
        repeat (2) run_frame(12'd0);

        // Hold 2, then add 5 without releasing.
        repeat (5) run_frame(12'b1 << 1);
        check("key2_accept", {28'd0, key}, 32'd2);
        repeat (6) run_frame((12'b1 << 1) | (12'b1 << 4));
`ifdef KEYPAD_SCANNER_GHOST_REJECT_EN
        check("key2_ghost_release", {28'd0, key}, 32'd10);
`else
        check("key2_held", {28'd0, key}, 32'd2);
`endif
        repeat (6) run_frame(12'd0);

        // Reset in the middle of a pending press of 9.
        repeat (2) run_frame(12'b1 << 8);
        run_frame(12'b1 << 8, 10);
        do_reset();
        repeat (3) run_frame(12'b1 << 8);
        check("key9_restart_pending", {28'd0, key}, 32'd10);
        run_frame(12'b1 << 8);
        check("key9_accept", {28'd0, key}, 32'd9);
        repeat (5) run_frame(12'd0);

        // Randomized segments: idle, single keys and occasional key pairs.
        for (int s = 0; s < 40; s++) begin
            k = '0;
            sel = int'($urandom_range(0, 99));
            if (sel >= 40) k[$urandom_range(0, 11)] = 1'b1;
            if (sel >= 85) k[$urandom_range(0, 11)] = 1'b1;
            hold = int'($urandom_range(1, 6));
            repeat (hold) run_frame(k);
        end
        repeat (6) run_frame(12'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
